// File: rtl/y_mc_ctrl_if.sv
// y_mc_ctrl_if: bundle between the multi-cycle controller and the yIF/yID/yEX/yDM/yWB datapath.
//   master (controller): receives ins, zero, imm, jTarget, if_ready, dm_ready;
//                        drives pc, if_req, RegWrite, ALUSrc, op, MemRead, MemWrite,
//                        Mem2Reg, retire, instret, err.
//   slave  (datapath):   the mirror image.
interface y_mc_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic [XLEN-1:0]  imm;
  logic [25:0]      jTarget;
  logic             if_ready;
  logic             dm_ready;
  logic [XLEN-1:0]  pc;
  logic             if_req;
  logic             RegWrite;
  logic             ALUSrc;
  logic [2:0]       op;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             err;

  modport master (
    input  ins, zero, imm, jTarget, if_ready, dm_ready,
    output pc, if_req, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, retire, instret, err
  );

  modport slave (
    output ins, zero, imm, jTarget, if_ready, dm_ready,
    input  pc, if_req, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, retire, instret, err
  );
endinterface

// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle control unit and PC register for the RV32 yIF..yWB datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath controls, updates PC (beq, jal),
// waits on if_ready/dm_ready with a timeout, counts retired instructions and traps on
// illegal opcodes or memory timeouts (TRAP is left only through rst_n).
// Ports: clk, rst_n (async, active low), bus (y_mc_ctrl_if.master).
module y_mc_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h28),
  parameter int unsigned     TIMEOUT  = 15,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  y_mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  // Last wait cycle that may still see ready; a miss here ends the wait in TRAP.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             reg_write_q, reg_write_d;
  logic             alu_src_q, alu_src_d;
  logic [2:0]       op_q, op_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             mem2reg_q, mem2reg_d;
  logic             retire_q, retire_d;
  logic             err_q, err_d;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_ir;

  assign opc       = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign pc_plus4  = pc_q + XLEN'(4);
  assign unused_ir = ^{ir_q[31:15], ir_q[11:7]};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    wait_cnt_d  = wait_cnt_q;
    reg_write_d = reg_write_q;
    alu_src_d   = alu_src_q;
    op_d        = op_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem2reg_d   = mem2reg_q;
    retire_d    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.if_ready) begin
          ir_d    = bus.ins;
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d   = S_EXEC;
        alu_src_d = 1'b1;
        op_d      = ALU_ADD;
        mem2reg_d = 1'b0;
        case (opc)
          OPC_R: begin
            alu_src_d = 1'b0;
            op_d      = (funct3 == 3'b110) ? ALU_OR : ALU_ADD;
          end
          OPC_ADDI, OPC_SW, OPC_JAL: ;
          OPC_LW:  mem2reg_d = 1'b1;
          OPC_BEQ: begin
            alu_src_d = 1'b0;
            op_d      = ALU_SUB;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (opc)
          OPC_BEQ: begin
            pc_d     = bus.zero ? pc_plus4 + (bus.imm << 1) : pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OPC_LW: begin
            mem_read_d = 1'b1;
            state_d    = S_MEM;
          end
          OPC_SW: begin
            mem_write_d = 1'b1;
            state_d     = S_MEM;
          end
          default: begin
            reg_write_d = 1'b1;
            state_d     = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dm_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (opc == OPC_LW) begin
            reg_write_d = 1'b1;
            state_d     = S_WB;
          end else begin
            pc_d     = pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        pc_d     = (opc == OPC_JAL) ? pc_plus4 + (XLEN'(bus.jTarget) << 2) : pc_plus4;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // Controls live from EXEC through WB; FETCH and TRAP always see them cleared.
    if (state_d == S_FETCH || state_d == S_TRAP) begin
      reg_write_d = 1'b0;
      alu_src_d   = 1'b0;
      op_d        = 3'b000;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem2reg_d   = 1'b0;
    end
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end
    instret_d = instret_q + CNT_W'(retire_d);
    err_d     = err_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      pc_q        <= RESET_PC;
      instret_q   <= '0;
      wait_cnt_q  <= '0;
      reg_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      op_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      retire_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      instret_q   <= instret_d;
      wait_cnt_q  <= wait_cnt_d;
      reg_write_q <= reg_write_d;
      alu_src_q   <= alu_src_d;
      op_q        <= op_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem2reg_q   <= mem2reg_d;
      retire_q    <= retire_d;
      err_q       <= err_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.if_req   = (state_q == S_FETCH);
  assign bus.RegWrite = reg_write_q;
  assign bus.ALUSrc   = alu_src_q;
  assign bus.op       = op_q;
  assign bus.MemRead  = mem_read_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.Mem2Reg  = mem2reg_q;
  assign bus.retire   = retire_q;
  assign bus.instret  = instret_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_y_mc_ctrl.sv
// Testbench for y_mc_ctrl: per-instruction phase model builds the expected output of
// every cycle; one negedge process compares the DUT against it.
module tb_y_mc_ctrl;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y_mc_ctrl_if #(.XLEN(32), .CNT_W(32)) bus();

  y_mc_ctrl #(.XLEN(32), .RESET_PC(32'h28), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        if_req;
    logic        rw;
    logic        as;
    logic [2:0]  op;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        ret;
    logic [31:0] instret;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_pc, m_cnt;
  logic        m_ret, m_err, m_trap;

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = '{pc: bus.pc, if_req: bus.if_req, rw: bus.RegWrite, as: bus.ALUSrc, op: bus.op,
              mr: bus.MemRead, mw: bus.MemWrite, m2r: bus.Mem2Reg, ret: bus.retire,
              instret: bus.instret, err: bus.err};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle t=%0t got pc=%h ifr=%b rw=%b as=%b op=%b mr=%b mw=%b m2r=%b ret=%b cnt=%0d err=%b want pc=%h ifr=%b rw=%b as=%b op=%b mr=%b mw=%b m2r=%b ret=%b cnt=%0d err=%b",
                   $time, a.pc, a.if_req, a.rw, a.as, a.op, a.mr, a.mw, a.m2r, a.ret, a.instret, a.err,
                   e.pc, e.if_req, e.rw, e.as, e.op, e.mr, e.mw, e.m2r, e.ret, e.instret, e.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic ifr, input logic rw, input logic as, input logic [2:0] o,
                              input logic mr, input logic mw, input logic m2r);
    exp_t e;
    e.pc = m_pc; e.if_req = ifr; e.rw = rw; e.as = as; e.op = o;
    e.mr = mr; e.mw = mw; e.m2r = m2r; e.ret = m_ret; e.instret = m_cnt; e.err = m_err;
    return e;
  endfunction

  task automatic step(input exp_t e);
    expq.push_back(e);
    m_ret = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    bus.ins      = $urandom;
    bus.zero     = 1'($urandom_range(0, 1));
    bus.imm      = $urandom;
    bus.jTarget  = 26'($urandom);
    bus.if_ready = 1'($urandom_range(0, 1));
    bus.dm_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    m_pc = 32'h28; m_cnt = '0; m_ret = 1'b0; m_err = 1'b0; m_trap = 1'b0;
    for (int i = 0; i < n; i++) begin
      rnd_inputs();
      step(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
  endtask

  task automatic enter_trap();
    m_err = 1'b1; m_trap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_inputs();
      step(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic complete(input logic [31:0] npc);
    m_pc = npc; m_cnt = m_cnt + 32'd1; m_ret = 1'b1;
  endtask

  // One instruction: fw idle fetch cycles before if_ready, dw idle MEM cycles before dm_ready.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] imm, input logic [25:0] jt,
                           input logic zv, input int fw, input int dw, input bit rst_mid);
    logic [6:0] o7;
    logic [2:0] aop;
    logic       as, m2r;
    bit         legal;
    o7 = ins[6:0];
    legal = 1; as = 1'b1; aop = 3'b010; m2r = 1'b0;
    case (o7)
      7'h33: begin as = 1'b0; aop = (ins[14:12] == 3'b110) ? 3'b001 : 3'b010; end
      7'h13, 7'h23, 7'h6F: ;
      7'h03: m2r = 1'b1;
      7'h63: begin as = 1'b0; aop = 3'b110; end
      default: legal = 0;
    endcase
    for (int i = 0; i <= fw; i++) begin
      if (i == TO) begin enter_trap(); return; end
      rnd_inputs();
      bus.if_ready = (i == fw);
      if (i == fw) bus.ins = ins;
      step(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    end
    rnd_inputs();
    step(mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    if (!legal) begin enter_trap(); return; end
    rnd_inputs();
    bus.zero = zv; bus.imm = imm;
    step(mk(1'b0, 1'b0, as, aop, 1'b0, 1'b0, m2r));
    if (o7 == 7'h63) begin
      complete(zv ? m_pc + 32'd4 + (imm << 1) : m_pc + 32'd4);
      return;
    end
    if (o7 == 7'h03 || o7 == 7'h23) begin
      for (int j = 0; j <= dw; j++) begin
        if (j == TO) begin enter_trap(); return; end
        if (rst_mid && j == 1) begin
          chk("mid_mw_before", 32'(bus.MemWrite), 32'd1);
          rst_n = 1'b0;
          #1;
          chk("mid_mw_async", 32'(bus.MemWrite), 32'd0);
          chk("mid_pc", bus.pc, 32'h28);
          chk("mid_instret", bus.instret, 32'd0);
          do_reset(2);
          return;
        end
        rnd_inputs();
        bus.dm_ready = (j == dw);
        step(mk(1'b0, 1'b0, as, aop, o7 == 7'h03, o7 == 7'h23, m2r));
      end
      if (o7 == 7'h23) begin complete(m_pc + 32'd4); return; end
    end
    rnd_inputs();
    bus.jTarget = jt;
    step(mk(1'b0, 1'b1, as, aop, 1'b0, 1'b0, m2r));
    complete(o7 == 7'h6F ? m_pc + 32'd4 + ({6'd0, jt} << 2) : m_pc + 32'd4);
  endtask

  initial begin
    logic [31:0] ins;
    int sel, fw, dw;
    rst_n = 1'b0;
    m_pc = 32'h28; m_cnt = '0; m_ret = 1'b0; m_err = 1'b0; m_trap = 1'b0;
    rnd_inputs();
    @(posedge clk);
    #1;
    do_reset(3);
    chk("rst_pc", bus.pc, 32'h28);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    run_instr(32'h002081B3, $urandom, 26'd0, 1'b0, 0, 0, 0);
    chk("add_pc", bus.pc, 32'h2C);
    chk("add_instret", bus.instret, 32'd1);
    chk("add_retire", 32'(bus.retire), 32'd1);
    run_instr(32'h00208463, 32'd8, 26'd0, 1'b1, 0, 0, 0);
    chk("beq_taken_pc", bus.pc, 32'h40);
    run_instr(32'h00208463, 32'd8, 26'd0, 1'b0, 1, 0, 0);
    chk("beq_not_pc", bus.pc, 32'h44);
    run_instr(32'h0000A183, $urandom, 26'd0, 1'b0, 2, 3, 0);
    chk("lw_pc", bus.pc, 32'h48);
    chk("lw_instret", bus.instret, 32'd4);
    run_instr(32'h0020A223, $urandom, 26'd0, 1'b0, 0, 3, 0);
    chk("sw_pc", bus.pc, 32'h4C);
    run_instr(32'h0080006F, $urandom, 26'd2, 1'b0, 0, 0, 0);
    chk("jal_pc", bus.pc, 32'h58);
    chk("jal_instret", bus.instret, 32'd6);
    run_instr(32'h0000007F, $urandom, 26'd0, 1'b0, 0, 0, 0);
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_pc", bus.pc, 32'h58);
    chk("ill_instret", bus.instret, 32'd6);

    do_reset(2);
    run_instr(32'h002081B3, $urandom, 26'd0, 1'b0, TO + 3, 0, 0);
    chk("ifto_err", 32'(bus.err), 32'd1);
    chk("ifto_ifreq", 32'(bus.if_req), 32'd0);
    do_reset(2);
    run_instr(32'h002081B3, $urandom, 26'd0, 1'b0, TO - 1, 0, 0);
    chk("if_edge_pc", bus.pc, 32'h2C);
    run_instr(32'h0000A183, $urandom, 26'd0, 1'b0, 0, TO - 1, 0);
    chk("dm_edge_pc", bus.pc, 32'h30);
    run_instr(32'h0020A223, $urandom, 26'd0, 1'b0, 0, TO, 0);
    chk("dmto_err", 32'(bus.err), 32'd1);
    chk("dmto_pc", bus.pc, 32'h30);

    do_reset(2);
    for (int k = 0; k < 250; k++) begin
      if (m_trap || $urandom_range(0, 99) < 3) do_reset(int'($urandom_range(1, 3)));
      ins = $urandom;
      sel = int'($urandom_range(0, 99));
      if (sel < 3) begin
        do ins[6:0] = 7'($urandom);
        while (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F});
      end else begin
        case (sel % 6)
          0: begin ins[6:0] = 7'h33; if ($urandom_range(0, 1) == 1) ins[14:12] = 3'b110; end
          1: ins[6:0] = 7'h13;
          2: ins[6:0] = 7'h03;
          3: ins[6:0] = 7'h23;
          4: ins[6:0] = 7'h63;
          default: ins[6:0] = 7'h6F;
        endcase
      end
      fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
      run_instr(ins, $urandom, 26'($urandom), 1'($urandom_range(0, 1)), fw, dw, 0);
    end

    do_reset(2);
    run_instr(32'h002081B3, $urandom, 26'd0, 1'b0, 0, 0, 0);
    run_instr(32'h0020A223, $urandom, 26'd0, 1'b0, 0, 3, 1);
    chk("post_rst_pc", bus.pc, 32'h28);
    run_instr(32'h002081B3, $urandom, 26'd0, 1'b0, 0, 0, 0);
    chk("recover_pc", bus.pc, 32'h2C);
    chk("recover_instret", bus.instret, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
